// File: rtl/writeback_unit.sv
// Register-file write-port owner: merges ALU and long-latency results onto one
// registered write port and tracks outstanding long-latency destinations.
module writeback_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic        WE,
  output logic [4:0]  A3,
  output logic [31:0] WD
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [4:0]    mem_rd_r   [FIFO_DEPTH];
  logic [31:0]   mem_data_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          commit_s;
  logic          sel_b_s;
  logic [4:0]    commit_rd_s;
  logic [31:0]   commit_data_s;

  logic          we_r;
  logic [4:0]    a3_r;
  logic [31:0]   wd_r;
  logic          wb_from_b_r;
  logic [31:0]   busy_r;
  logic [31:0]   busy_nxt_s;

  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign empty_s = (count_r == CW'(0));
  assign b_ready = !full_s;
  assign a_stall = full_s && a_valid;
  assign push_s  = b_valid && !full_s;
  assign pop_s   = sel_b_s;

  assign WE   = we_r;
  assign A3   = a3_r;
  assign WD   = wd_r;
  assign busy = busy_r;

  // Arbitration: a full buffer forces the head out, otherwise A has priority.
  always_comb begin
    commit_s      = 1'b0;
    sel_b_s       = 1'b0;
    commit_rd_s   = 5'd0;
    commit_data_s = 32'd0;
    if (full_s) begin
      commit_s      = 1'b1;
      sel_b_s       = 1'b1;
      commit_rd_s   = mem_rd_r[rd_ptr_r];
      commit_data_s = mem_data_r[rd_ptr_r];
    end else if (a_valid) begin
      commit_s      = 1'b1;
      commit_rd_s   = a_rd;
      commit_data_s = a_data;
    end else if (!empty_s) begin
      commit_s      = 1'b1;
      sel_b_s       = 1'b1;
      commit_rd_s   = mem_rd_r[rd_ptr_r];
      commit_data_s = mem_data_r[rd_ptr_r];
    end else begin
      commit_s      = 1'b0;
    end
  end

  // Buffer occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Scoreboard update; a set on the same edge overrides the clear.
  always_comb begin
    busy_nxt_s = busy_r;
    if (we_r && wb_from_b_r) begin
      busy_nxt_s[a3_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Long-latency result buffer storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_rd_r[i]   <= 5'd0;
        mem_data_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        mem_rd_r[wr_ptr_r]   <= b_rd;
        mem_data_r[wr_ptr_r] <= b_data;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered write port; address and data hold when nothing commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r        <= 1'b0;
      a3_r        <= 5'd0;
      wd_r        <= 32'd0;
      wb_from_b_r <= 1'b0;
    end else if (commit_s) begin
      we_r        <= (commit_rd_s != 5'd0);
      a3_r        <= commit_rd_s;
      wd_r        <= commit_data_s;
      wb_from_b_r <= sel_b_s;
    end else begin
      we_r        <= 1'b0;
      wb_from_b_r <= 1'b0;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scenario bench for writeback_unit: expected writes are queued at stimulus
// time and matched against the write port whenever WE is high.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = 5'd0;
  logic [31:0] a_data = 32'd0;
  logic        a_stall;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_rd = 5'd0;
  logic [31:0] b_data = 32'd0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] busy;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  writeback_unit #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy(busy), .WE(WE), .A3(A3), .WD(WD)
  );

  always #5 clk = ~clk;

  // Every register-file write must match the oldest predicted write.
  always @(negedge clk) begin
    if (WE === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got A3=%0d WD=%h, expected no write", A3, WD);
      end else begin
        mon_e = exp_q.pop_front();
        if (A3 !== mon_e.rd || WD !== mon_e.data) begin
          bad++;
          $display("FAIL wb_order: got A3=%0d WD=%h, expected A3=%0d WD=%h",
                   A3, WD, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'($urandom); a_rd = 5'($urandom); a_data = $urandom;
      b_valid = 1'($urandom); b_rd = 5'($urandom); b_data = $urandom;
      issue_valid = 1'($urandom); issue_rd = 5'($urandom);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    a_valid = 1'b1;
    #1;
    total++; if (WE !== 1'b0)    begin bad++; $display("FAIL rst_we: got %b want 0", WE); end
    total++; if (A3 !== 5'd0)    begin bad++; $display("FAIL rst_a3: got %0d want 0", A3); end
    total++; if (WD !== 32'd0)   begin bad++; $display("FAIL rst_wd: got %h want 0", WD); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL rst_busy: got %h want 0", busy); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL rst_b_ready: got %b want 1", b_ready); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_a_stall: got %b want 0", a_stall); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_a_path();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    step();
    a_rd = 5'd0; a_data = 32'h00001234;
    total++; if (WE !== 1'b1)        begin bad++; $display("FAIL a_we: got %b want 1", WE); end
    total++; if (A3 !== 5'd5)        begin bad++; $display("FAIL a_a3: got %0d want 5", A3); end
    total++; if (WD !== 32'hDEADBEEF) begin bad++; $display("FAIL a_wd: got %h want deadbeef", WD); end
    step();
    a_valid = 1'b0;
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL a_rd0_we: got %b want 0", WE); end
    step();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL sb_set: got %b want 1", busy[7]); end
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hCAFE0001;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sb_b_ready: got %b want 1", b_ready); end
    exp_q.push_back('{rd: 5'd7, data: 32'hCAFE0001});
    step();
    b_valid = 1'b0;
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL sb_no_bypass: got %b want 0", WE); end
    step();
    total++; if (WE !== 1'b1 || A3 !== 5'd7)
      begin bad++; $display("FAIL sb_commit: got WE=%b A3=%0d want WE=1 A3=7", WE, A3); end
    total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL sb_hold: got %b want 1", busy[7]); end
    step();
    total++; if (busy[7] !== 1'b0) begin bad++; $display("FAIL sb_clear: got %b want 0", busy[7]); end
    step();
  endtask

  task automatic test_contention();
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'h0000A010;
    b_valid = 1'b1; b_rd = 5'd3;  b_data = 32'h0000B003;
    exp_q.push_back('{rd: 5'd10, data: 32'h0000A010});
    step();
    a_rd = 5'd11; a_data = 32'h0000A011;
    b_rd = 5'd4;  b_data = 32'h0000B004;
    total++; if (b_ready !== 1'b1 || a_stall !== 1'b0)
      begin bad++; $display("FAIL ct_fill: got b_ready=%b a_stall=%b want 1/0", b_ready, a_stall); end
    exp_q.push_back('{rd: 5'd11, data: 32'h0000A011});
    step();
    b_valid = 1'b0;
    a_rd = 5'd9; a_data = 32'h0000A009;
    #1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL ct_b_ready: got %b want 0", b_ready); end
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL ct_a_stall: got %b want 1", a_stall); end
    exp_q.push_back('{rd: 5'd3, data: 32'h0000B003});
    step();
    total++; if (a_stall !== 1'b0 || b_ready !== 1'b1)
      begin bad++; $display("FAIL ct_release: got a_stall=%b b_ready=%b want 0/1", a_stall, b_ready); end
    exp_q.push_back('{rd: 5'd9, data: 32'h0000A009});
    step();
    a_valid = 1'b0;
    exp_q.push_back('{rd: 5'd4, data: 32'h0000B004});
    step();
    step();
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL ct_drain: got %b want 0", WE); end
  endtask

  task automatic test_set_clear();
    issue_valid = 1'b1; issue_rd = 5'd6;
    step();
    issue_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h66660001;
    exp_q.push_back('{rd: 5'd6, data: 32'h66660001});
    step();
    b_valid = 1'b0;
    step();
    issue_valid = 1'b1; issue_rd = 5'd6;
    total++; if (WE !== 1'b1 || A3 !== 5'd6)
      begin bad++; $display("FAIL sc_commit: got WE=%b A3=%0d want WE=1 A3=6", WE, A3); end
    step();
    issue_valid = 1'b0;
    total++; if (busy[6] !== 1'b1) begin bad++; $display("FAIL sc_set_wins: got %b want 1", busy[6]); end
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h66660002;
    exp_q.push_back('{rd: 5'd6, data: 32'h66660002});
    step();
    b_valid = 1'b0;
    repeat (2) step();
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL sc_final_clear: got %h want 0", busy); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    issue_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h0000C012;
    b_valid = 1'b1; b_rd = 5'd3;  b_data = 32'h5AA50003;
    exp_q.push_back('{rd: 5'd12, data: 32'h0000C012});
    step();
    a_rd = 5'd13; a_data = 32'h0000C013;
    b_rd = 5'd4;  b_data = 32'h5AA50004;
    exp_q.push_back('{rd: 5'd13, data: 32'h0000C013});
    step();
    idle_inputs();
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rm_full: got b_ready=%b want 0", b_ready); end
    total++; if (busy !== 32'h00000018) begin bad++; $display("FAIL rm_busy: got %h want 00000018", busy); end
    rst = 1'b1;
    step();
    total++; if (WE !== 1'b0)      begin bad++; $display("FAIL rm_we: got %b want 0", WE); end
    total++; if (busy !== 32'd0)   begin bad++; $display("FAIL rm_busy_clr: got %h want 0", busy); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL rm_b_ready: got %b want 1", b_ready); end
    rst = 1'b0;
    repeat (4) step();
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL rm_stale: got %b want 0", WE); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_rd = 5'(16 + i); a_data = 32'hB2B00000 + 32'(i);
      exp_q.push_back('{rd: 5'(16 + i), data: 32'hB2B00000 + 32'(i)});
      step();
      total++; if (WE !== 1'b1) begin bad++; $display("FAIL b2b_we: got %b want 1 at %0d", WE, i); end
    end
    idle_inputs();
    repeat (2) step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_a_path();
    test_scoreboard();
    test_contention();
    test_set_clear();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wb_missing: got %0d writes outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
